mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-port synchronous memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined RV32I core.
- Resolves the IF/MEM structural hazard by granting at most one access per cycle and stalling the loser.
- Data access has priority; a saturating starvation counter guarantees fetch progress.
- Sits between cpu pipeline stages and the unified memory macro.

Parameters:
ADDR_W, 10, word-address width of shared memory (depth 2**ADDR_W words)
STARVE_MAX, 3, consecutive denied IF cycles after which IF wins the next conflict

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
if_req  input  1  fetch request; held stable with if_addr while if_stall=1
if_addr  input  32  byte address of instruction
if_stall  output  1  combinational: if_req & ~if_gnt
if_valid  output  1  one-cycle pulse, if_rdata valid, one cycle after IF grant
if_rdata  output  32  fetched instruction
dm_req  input  1  data request; dm_* held stable while dm_stall=1
dm_we  input  1  1=store, 0=load
dm_be  input  4  byte enables, already lane-aligned (sb/sh/sw)
dm_addr  input  32  byte address
dm_wdata  input  32  store data, lane-aligned
dm_stall  output  1  combinational: dm_req & ~dm_gnt
dm_valid  output  1  one-cycle pulse one cycle after DM grant (load data or store ack)
dm_rdata  output  32  load data (0 on store ack)
mem_en  output  1  memory access enable
mem_we  output  1  memory write enable
mem_be  output  4  memory byte enables
mem_addr  output  ADDR_W  word address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, valid one cycle after mem_en & ~mem_we

Behaviour:
- Reset: state IDLE, starve_cnt=0, if_valid=dm_valid=0, if_rdata=dm_rdata=0; stall outputs follow requests combinationally (dm_req alone -> dm_stall=0 only after reset released). While rst=1 grants forced 0, mem_en=0, both stalls = respective req.
- Grant (combinational, same cycle):
  - only dm_req -> dm_gnt; only if_req -> if_gnt.
  - both: if_gnt when starve_cnt==STARVE_MAX, else dm_gnt.
  - none -> mem_en=0.
- Memory drive: granted requester's address bits [ADDR_W+1:2] -> mem_addr; low 2 bits ignored. IF: mem_we=0, mem_be=4'hF. DM: mem_we=dm_we, mem_be=dm_be, mem_wdata=dm_wdata. mem_wdata=0 when not DM store.
- FSM (registered, tracks in-flight access):
  - IDLE / RET_IF / RET_DM; next state = RET_IF on if_gnt, RET_DM on dm_gnt, else IDLE.
  - RET_IF: if_valid=1, if_rdata=mem_rdata.
  - RET_DM: dm_valid=1, dm_rdata = mem_rdata for load, 0 for store.
  - Back-to-back grants allowed: one access per cycle, full throughput.
- Latency: grant cycle N -> valid pulse cycle N+1. Stalled requester sees 0 grant until chosen; no request queuing inside block.
- starve_cnt: +1 when if_req & ~if_gnt, saturate at STARVE_MAX; cleared to 0 on if_gnt or when if_req=0.
- Reset asserted mid-access: in-flight return dropped, no valid pulse in following cycle, counter cleared.
- Store to address also being fetched in same conflict: DM wins (unless starved), fetch next cycle observes new data.

Test Plan:
- Reset: rst=1 3 cycles with if_req=1 -> mem_en=0, if_valid=0, starve_cnt=0; release -> IF granted first cycle, if_valid pulse next cycle with mem word 0.
- IF only: if_req=1, addrs 0,4,8 consecutive -> mem_addr 0,1,2, if_valid every cycle from 2nd, if_stall=0 throughout.
- Conflict: if_req=1 addr 12, dm_req=1 store sb be=4'b0001 addr 8 wdata 0x0A -> dm granted, if_stall=1 one cycle, dm_valid next cycle, mem word 2 byte0=0x0A; IF granted following cycle.
- Starvation: dm_req held high 6 cycles, if_req high -> dm granted 3 cycles, 4th cycle IF granted with dm_stall=1, counter resets, DM resumes.
- Load return: mem word 2 = 0x0000000A, dm load addr 8 -> dm_rdata=0x0000000A with dm_valid one cycle later; store ack returns dm_rdata=0.
- Reset mid-op: DM load granted cycle N, rst=1 at N+1 -> no dm_valid, state IDLE, outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store.
// Data side wins conflicts unless fetch has been denied STARVE_MAX cycles in a row.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_stall,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_stall,
  output logic              dm_valid,
  output logic [31:0]       dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, RET_IF, RET_DM} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             ret_store;
  logic             if_gnt;
  logic             dm_gnt;

  // Byte-offset and out-of-range address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              dm_addr[31:ADDR_W+2], dm_addr[1:0]};

  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst) begin
      if (if_req && dm_req) begin
        if (starve_cnt == CNT_MAX) if_gnt = 1'b1;
        else                       dm_gnt = 1'b1;
      end else begin
        if_gnt = if_req;
        dm_gnt = dm_req;
      end
    end
  end

  assign if_stall = if_req & ~if_gnt;
  assign dm_stall = dm_req & ~dm_gnt;

  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (if_gnt) begin
      mem_be   = 4'hF;
      mem_addr = if_addr[ADDR_W+1:2];
    end else if (dm_gnt) begin
      mem_we    = dm_we;
      mem_be    = dm_be;
      mem_addr  = dm_addr[ADDR_W+1:2];
      mem_wdata = dm_we ? dm_wdata : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ret_store  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ret_store <= dm_gnt & dm_we;
      if (if_gnt || !if_req)
        starve_cnt <= '0;
      else if (starve_cnt != CNT_MAX)
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Return outputs are masked by rst so a reset arriving mid-access drops the pulse.
  always_comb begin
    state_nxt = IDLE;
    if_valid  = 1'b0;
    if_rdata  = 32'h0;
    dm_valid  = 1'b0;
    dm_rdata  = 32'h0;
    if (if_gnt)      state_nxt = RET_IF;
    else if (dm_gnt) state_nxt = RET_DM;
    case (state)
      RET_IF: begin
        if (!rst) begin
          if_valid = 1'b1;
          if_rdata = mem_rdata;
        end
      end
      RET_DM: begin
        if (!rst) begin
          dm_valid = 1'b1;
          dm_rdata = ret_store ? 32'h0 : mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: reference arbitration model plus return scoreboard against a behavioural memory.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 10;
  localparam int STARVE_MAX = 3;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_stall;
  logic              if_valid;
  logic [31:0]       if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [3:0]        dm_be;
  logic [31:0]       dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_stall;
  logic              dm_valid;
  logic [31:0]       dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_stall(dm_stall), .dm_valid(dm_valid),
    .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural single-port memory driven by the DUT.
  logic [31:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  typedef struct {
    bit          is_dm;
    logic [31:0] data;
  } ret_t;

  ret_t        sb_q[$];
  logic [31:0] ref_mem [0:DEPTH-1];
  int          m_cnt;
  int          n_cmp;
  int          n_err;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock: check returns and this cycle's arbitration at negedge, then advance.
  task automatic cycle();
    ret_t        r;
    logic        g_if;
    logic        g_dm;
    int          idx;
    @(negedge clk);
    if (sb_q.size() > 0 && !rst) begin
      r = sb_q.pop_front();
      if (r.is_dm) begin
        chk_eq("dm_valid", {31'b0, dm_valid}, 32'd1);
        chk_eq("dm_rdata", dm_rdata, r.data);
        chk_eq("if_valid_idle", {31'b0, if_valid}, 32'd0);
      end else begin
        chk_eq("if_valid", {31'b0, if_valid}, 32'd1);
        chk_eq("if_rdata", if_rdata, r.data);
        chk_eq("dm_valid_idle", {31'b0, dm_valid}, 32'd0);
      end
    end else begin
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      chk_eq("if_valid_none", {31'b0, if_valid}, 32'd0);
      chk_eq("dm_valid_none", {31'b0, dm_valid}, 32'd0);
      if (rst) begin
        chk_eq("if_rdata_rst", if_rdata, 32'h0);
        chk_eq("dm_rdata_rst", dm_rdata, 32'h0);
      end
    end

    g_if = 1'b0;
    g_dm = 1'b0;
    if (!rst) begin
      if (if_req && dm_req) begin
        if (m_cnt == STARVE_MAX) g_if = 1'b1;
        else                     g_dm = 1'b1;
      end else begin
        g_if = if_req;
        g_dm = dm_req;
      end
    end
    chk_eq("if_stall", {31'b0, if_stall}, {31'b0, if_req & ~g_if});
    chk_eq("dm_stall", {31'b0, dm_stall}, {31'b0, dm_req & ~g_dm});
    chk_eq("mem_en", {31'b0, mem_en}, {31'b0, g_if | g_dm});
    if (g_if) begin
      idx = int'(if_addr[ADDR_W+1:2]);
      chk_eq("if_mem_addr", {22'b0, mem_addr}, idx);
      chk_eq("if_mem_we", {31'b0, mem_we}, 32'd0);
      chk_eq("if_mem_be", {28'b0, mem_be}, 32'hF);
      chk_eq("if_mem_wdata", mem_wdata, 32'h0);
      sb_q.push_back('{is_dm: 1'b0, data: ref_mem[idx]});
    end
    if (g_dm) begin
      idx = int'(dm_addr[ADDR_W+1:2]);
      chk_eq("dm_mem_addr", {22'b0, mem_addr}, idx);
      chk_eq("dm_mem_we", {31'b0, mem_we}, {31'b0, dm_we});
      chk_eq("dm_mem_be", {28'b0, mem_be}, {28'b0, dm_be});
      chk_eq("dm_mem_wdata", mem_wdata, dm_we ? dm_wdata : 32'h0);
      sb_q.push_back('{is_dm: 1'b1, data: dm_we ? 32'h0 : ref_mem[idx]});
      if (dm_we)
        for (int b = 0; b < 4; b++)
          if (dm_be[b]) ref_mem[idx][8*b +: 8] = dm_wdata[8*b +: 8];
    end

    if (rst || g_if || !if_req) m_cnt = 0;
    else if (m_cnt < STARVE_MAX) m_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic we, input logic [3:0] be,
                       input logic [31:0] da, input logic [31:0] wd);
    if_req   = ir;
    if_addr  = ia;
    dm_req   = dr;
    dm_we    = we;
    dm_be    = be;
    dm_addr  = da;
    dm_wdata = wd;
    cycle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = (i == 2) ? 32'h0 : (32'hC0DE0000 | i);
      ref_mem[i] = (i == 2) ? 32'h0 : (32'hC0DE0000 | i);
    end

    // Reset held with fetch pending: no grant, stall follows request.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(1, 32'd0, 0, 0, 4'h0, 32'd0, 32'd0);
    rst = 1'b0;

    // Fetch only, back-to-back.
    drive(1, 32'd0, 0, 0, 4'h0, 32'd0, 32'd0);
    drive(1, 32'd4, 0, 0, 4'h0, 32'd0, 32'd0);
    drive(1, 32'd8, 0, 0, 4'h0, 32'd0, 32'd0);

    // Conflict: byte store wins, fetch follows; upper wdata bytes must be masked.
    drive(1, 32'd12, 1, 1, 4'b0001, 32'd8, 32'hFFFFFF0A);
    drive(1, 32'd12, 0, 0, 4'h0, 32'd0, 32'd0);

    // Load returns stored byte; word store acks with zero.
    drive(0, 32'd0, 1, 0, 4'hF, 32'd8, 32'd0);
    drive(0, 32'd0, 1, 1, 4'hF, 32'd16, 32'h12345678);

    // Store and fetch to same word: fetch sees new halfword.
    drive(1, 32'd8, 1, 1, 4'b0011, 32'd8, 32'h5555BEEF);
    drive(1, 32'd8, 0, 0, 4'h0, 32'd0, 32'd0);

    // Starvation: loads held 6 cycles against fetch.
    for (int i = 0; i < 6; i++) drive(1, 32'd20, 1, 0, 4'hF, 32'd16, 32'd0);
    drive(1, 32'd20, 0, 0, 4'h0, 32'd0, 32'd0);
    drive(0, 32'd0, 0, 0, 4'h0, 32'd0, 32'd0);

    // Reset arriving the cycle after a load grant drops the return.
    drive(0, 32'd0, 1, 0, 4'hF, 32'd16, 32'd0);
    rst = 1'b1;
    drive(0, 32'd0, 1, 0, 4'hF, 32'd16, 32'd0);
    rst = 1'b0;
    drive(0, 32'd0, 0, 0, 4'h0, 32'd0, 32'd0);
    drive(1, 32'd4, 1, 0, 4'hF, 32'd12, 32'd0);
    drive(0, 32'd0, 0, 0, 4'h0, 32'd0, 32'd0);
    drive(0, 32'd0, 0, 0, 4'h0, 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
